// File: rtl/led_scan_mux.sv
// Time-multiplexed LED display driver with dead time, PWM brightness, per-digit blank/blink
// and frame-consistent shadowing of the display inputs.
module led_scan_mux #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SEG_W        = 8,
    parameter int unsigned SCAN_DIV     = 65536,
    parameter int unsigned DEAD_CYCLES  = 1,
    parameter int unsigned PWM_BITS     = 4,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          enable_i,
    input  logic [NUM_DIGITS*SEG_W-1:0]   digit_data_i,
    input  logic [NUM_DIGITS-1:0]         digit_blank_i,
    input  logic [NUM_DIGITS-1:0]         blink_en_i,
    input  logic [PWM_BITS-1:0]           brightness_i,
    output logic [SEG_W-1:0]              led_out_o,
    output logic [NUM_DIGITS-1:0]         led_enb_o,
    output logic [$clog2(NUM_DIGITS)-1:0] cur_digit_o,
    output logic                          frame_start_o
);

    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned DW = $clog2(NUM_DIGITS);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] SLast = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DLast = DW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FLast = FW'(BLINK_FRAMES - 1);

    logic [SW-1:0] s_q, s_d;
    logic [DW-1:0] d_q, d_d;
    logic [FW-1:0] f_q, f_d;
    logic          bp_q, bp_d;

    logic [NUM_DIGITS*SEG_W-1:0] data_sh_q;
    logic [NUM_DIGITS-1:0]       blank_sh_q;
    logic [NUM_DIGITS-1:0]       blink_sh_q;
    logic [PWM_BITS-1:0]         bright_sh_q;

    logic [SEG_W-1:0]      led_out_q;
    logic [NUM_DIGITS-1:0] led_enb_q;
    logic [DW-1:0]         cur_digit_q;
    logic                  frame_start_q;

    logic                        load;
    logic                        digit_on;
    logic                        pwm_on;
    logic [NUM_DIGITS*SEG_W-1:0] data_eff;
    logic [NUM_DIGITS-1:0]       blank_eff;
    logic [NUM_DIGITS-1:0]       blink_eff;
    logic [PWM_BITS-1:0]         bright_eff;

    assign load = enable_i && (s_q == '0) && (d_q == '0);

    // In the load cycle the live inputs bypass the shadows, so the display never shows stale
    // values from a previous run even with zero dead time.
    always_comb begin
        data_eff   = load ? digit_data_i  : data_sh_q;
        blank_eff  = load ? digit_blank_i : blank_sh_q;
        blink_eff  = load ? blink_en_i    : blink_sh_q;
        bright_eff = load ? brightness_i  : bright_sh_q;
        pwm_on     = (&bright_eff) || (s_q[PWM_BITS-1:0] < bright_eff);
        digit_on   = enable_i && (s_q >= SW'(DEAD_CYCLES)) && !blank_eff[d_q]
                     && !(blink_eff[d_q] && bp_q) && pwm_on;
    end

    always_comb begin
        s_d  = s_q;
        d_d  = d_q;
        f_d  = f_q;
        bp_d = bp_q;
        if (!enable_i) begin
            s_d  = '0;
            d_d  = '0;
            f_d  = '0;
            bp_d = 1'b0;
        end else if (s_q == SLast) begin
            s_d = '0;
            if (d_q == DLast) begin
                d_d = '0;
                if (f_q == FLast) begin
                    f_d  = '0;
                    bp_d = ~bp_q;
                end else begin
                    f_d = f_q + FW'(1);
                end
            end else begin
                d_d = d_q + DW'(1);
            end
        end else begin
            s_d = s_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s_q           <= '0;
            d_q           <= '0;
            f_q           <= '0;
            bp_q          <= 1'b0;
            data_sh_q     <= '0;
            blank_sh_q    <= '0;
            blink_sh_q    <= '0;
            bright_sh_q   <= '0;
            led_out_q     <= '0;
            led_enb_q     <= '1;
            cur_digit_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            d_q  <= d_d;
            f_q  <= f_d;
            bp_q <= bp_d;
            if (load) begin
                data_sh_q   <= digit_data_i;
                blank_sh_q  <= digit_blank_i;
                blink_sh_q  <= blink_en_i;
                bright_sh_q <= brightness_i;
            end
            led_out_q     <= digit_on ? data_eff[int'(d_q)*SEG_W +: SEG_W] : '0;
            led_enb_q     <= digit_on ? ~(NUM_DIGITS'(1) << d_q) : '1;
            cur_digit_q   <= enable_i ? d_q : '0;
            frame_start_q <= load;
        end
    end

    assign led_out_o     = led_out_q;
    assign led_enb_o     = led_enb_q;
    assign cur_digit_o   = cur_digit_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_led_scan_mux.sv
// Randomised and directed bench for led_scan_mux against a time-index reference model.
module tb_led_scan_mux;

    localparam int N      = 4;
    localparam int SEG    = 8;
    localparam int DIV    = 8;
    localparam int DEAD   = 1;
    localparam int PB     = 2;
    localparam int BLINK  = 2;
    localparam int FRAME  = N * DIV;
    localparam int BFULL  = (1 << PB) - 1;

    logic              clk;
    logic              rstb;
    logic              enable;
    logic [N*SEG-1:0]  digit_data;
    logic [N-1:0]      digit_blank;
    logic [N-1:0]      blink_en;
    logic [PB-1:0]     brightness;
    logic [SEG-1:0]    led_out;
    logic [N-1:0]      led_enb;
    logic [1:0]        cur_digit;
    logic              frame_start;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: t counts cycles since the current scan run began.
    int               t = 0;
    logic [N*SEG-1:0] sh_data;
    logic [N-1:0]     sh_blank;
    logic [N-1:0]     sh_blink;
    logic [PB-1:0]    sh_bright;

    led_scan_mux #(
        .NUM_DIGITS  (N),
        .SEG_W       (SEG),
        .SCAN_DIV    (DIV),
        .DEAD_CYCLES (DEAD),
        .PWM_BITS    (PB),
        .BLINK_FRAMES(BLINK)
    ) u_dut (
        .clk          (clk),
        .rstb         (rstb),
        .enable_i     (enable),
        .digit_data_i (digit_data),
        .digit_blank_i(digit_blank),
        .blink_en_i   (blink_en),
        .brightness_i (brightness),
        .led_out_o    (led_out),
        .led_enb_o    (led_enb),
        .cur_digit_o  (cur_digit),
        .frame_start_o(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, ".led_enb"}, 32'(led_enb), 32'hF);
        check_eq({tag, ".led_out"}, 32'(led_out), 32'h0);
        check_eq({tag, ".cur_digit"}, 32'(cur_digit), 32'h0);
        check_eq({tag, ".frame_start"}, 32'(frame_start), 32'h0);
    endtask

    // One clock: predict the pins for the next cycle from the model, then compare.
    task automatic tick();
        int         s, d, bp;
        bit         on;
        logic [3:0] e_enb;
        logic [7:0] e_out;
        int         e_cur;
        bit         e_fs;
        e_enb = 4'hF;
        e_out = 8'h00;
        e_cur = 0;
        e_fs  = 1'b0;
        if (rstb && enable) begin
            if (t % FRAME == 0) begin
                sh_data   = digit_data;
                sh_blank  = digit_blank;
                sh_blink  = blink_en;
                sh_bright = brightness;
                e_fs      = 1'b1;
            end
            s  = t % DIV;
            d  = (t / DIV) % N;
            bp = ((t / FRAME) / BLINK) % 2;
            on = (s >= DEAD) && !sh_blank[d] && !(sh_blink[d] && bp == 1)
                 && (int'(sh_bright) == BFULL || (s % (1 << PB)) < int'(sh_bright));
            e_cur = d;
            if (on) begin
                e_enb = 4'hF & ~(4'h1 << d);
                e_out = sh_data[d*SEG +: SEG];
            end
        end
        @(posedge clk);
        #1;
        check_eq("led_enb", 32'(led_enb), 32'(e_enb));
        check_eq("led_out", 32'(led_out), 32'(e_out));
        check_eq("cur_digit", 32'(cur_digit), 32'(e_cur));
        check_eq("frame_start", 32'(frame_start), 32'(e_fs));
        if (!rstb || !enable) t = 0;
        else t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next cycle to be simulated has the given in-frame position.
    task automatic seek(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) tick();
    endtask

    initial begin
        rstb        = 1'b0;
        enable      = 1'b0;
        digit_data  = '0;
        digit_blank = '0;
        blink_en    = '0;
        brightness  = '0;
        @(posedge clk);
        #1;
        check_dark("reset");
        rstb = 1'b1;
        run(6);

        // Full scan at full brightness.
        digit_data = {8'h44, 8'h33, 8'h22, 8'h11};
        brightness = 2'd3;
        enable     = 1'b1;
        run(2 * FRAME + 1);

        // PWM codes 2 and 0.
        brightness = 2'd2;
        run(2 * FRAME);
        brightness = 2'd0;
        run(2 * FRAME);
        brightness = 2'd3;
        run(FRAME);

        // Mid-frame data change lands only at the next frame.
        seek(2 * DIV + 3);
        digit_data[7:0] = 8'hAA;
        run(2 * FRAME);

        // Blanking, then blinking from a fresh start.
        digit_blank = 4'b0100;
        run(2 * FRAME);
        digit_blank = 4'b0000;
        blink_en    = 4'b0001;
        enable      = 1'b0;
        tick();
        enable = 1'b1;
        run(6 * FRAME + 2);
        blink_en = 4'b0000;

        // Enable drop at d=3, s=5, then restart.
        seek(3 * DIV + 5);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        run(FRAME + 2);

        // Asynchronous reset mid-scan.
        seek(DIV + 4);
        rstb = 1'b0;
        #1;
        check_dark("async_rst");
        t = 0;
        run(3);
        rstb = 1'b1;
        run(FRAME + 3);

        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 2) == 0) digit_data = $urandom;
            if ($urandom_range(0, 2) == 0) brightness = PB'($urandom_range(0, BFULL));
            if ($urandom_range(0, 3) == 0) digit_blank = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) blink_en = N'($urandom_range(0, 15));
            enable = ($urandom_range(0, 9) != 0);
            run($urandom_range(1, 70));
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
        $finish;
    end

endmodule
